exec_stage: RTL and testbench

Execute stage sitting directly downstream of the register file: consumes the operand pair, ALU opcode and destination register index, computes the result, and presents a registered writeback packet to the writeback stage, which drives the register file write port. Single-cycle ALU ops complete with one cycle of latency. Multiply and divide, when compiled in, run on an iterative unit that stalls upstream through a ready/valid handshake.

---
 rtl/exec_pkg.sv | 110 +++++++++++
 rtl/muldiv_iter.sv | 105 ++++++++++
 rtl/exec_stage.sv | 129 ++++++++++++
 tb/tb_exec_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types, constants and pure ALU helpers for the execute stage.
// EXEC_MULDIV_EN (set at build time) selects whether opcodes 16-20 are implemented.
package exec_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 64;
  localparam int unsigned OP_W           = 6;
  localparam int unsigned REG_W          = 5;
  localparam int unsigned ITER_COUNT     = 64;
  localparam int unsigned CNT_W          = 7;

  localparam logic [REG_W-1:0]          REG_ZERO   = 5'd0;
  localparam logic [BUS_DATA_WIDTH-1:0] SIGNED_MIN = {1'b1, {(BUS_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9,
    OP_ADDW = 6'd10,
    OP_MUL  = 6'd16,
    OP_DIV  = 6'd17,
    OP_DIVU = 6'd18,
    OP_REM  = 6'd19,
    OP_REMU = 6'd20
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                      valid;
    logic                      write_en;
    logic [REG_W-1:0]          addr;
    logic [BUS_DATA_WIDTH-1:0] data;
  } wb_pkt_t;

  typedef struct packed {
    logic                      ok;
    logic [BUS_DATA_WIDTH-1:0] data;
  } alu_res_t;

  // Single-cycle ALU; ok=0 flags an opcode this function does not implement.
  function automatic alu_res_t alu_single(input logic [OP_W-1:0] op,
                                          input logic [BUS_DATA_WIDTH-1:0] a,
                                          input logic [BUS_DATA_WIDTH-1:0] b);
    alu_res_t    res;
    logic [31:0] w32;
    res.ok   = 1'b1;
    res.data = '0;
    w32      = 32'(a[31:0] + b[31:0]);
    case (op)
      OP_ADD:  res.data = a + b;
      OP_SUB:  res.data = a - b;
      OP_AND:  res.data = a & b;
      OP_OR:   res.data = a | b;
      OP_XOR:  res.data = a ^ b;
      OP_SLL:  res.data = a << b[5:0];
      OP_SRL:  res.data = a >> b[5:0];
      OP_SRA:  res.data = BUS_DATA_WIDTH'($signed(a) >>> b[5:0]);
      OP_SLT:  res.data = {63'd0, ($signed(a) < $signed(b))};
      OP_SLTU: res.data = {63'd0, (a < b)};
      OP_ADDW: res.data = {{32{w32[31]}}, w32};
      default: res.ok   = 1'b0;
    endcase
    return res;
  endfunction

  // Divide cases resolved without iterating: divide by zero and signed overflow.
  function automatic alu_res_t div_shortcut(input logic [OP_W-1:0] op,
                                            input logic [BUS_DATA_WIDTH-1:0] a,
                                            input logic [BUS_DATA_WIDTH-1:0] b);
    alu_res_t res;
    logic     is_rem;
    logic     is_signed;
    res.ok    = 1'b0;
    res.data  = '0;
    is_rem    = (op == OP_REM) || (op == OP_REMU);
    is_signed = (op == OP_DIV) || (op == OP_REM);
    if (b == '0) begin
      res.ok   = 1'b1;
      res.data = is_rem ? a : '1;
    end else if (is_signed && (a == SIGNED_MIN) && (b == '1)) begin
      res.ok   = 1'b1;
      res.data = is_rem ? '0 : a;
    end
    return res;
  endfunction

  function automatic wb_pkt_t make_pkt(input logic defined,
                                       input logic [REG_W-1:0] addr,
                                       input logic [BUS_DATA_WIDTH-1:0] data);
    wb_pkt_t pkt;
    pkt.valid    = 1'b1;
    pkt.write_en = defined && (addr != REG_ZERO);
    pkt.addr     = addr;
    pkt.data     = defined ? data : '0;
    return pkt;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / restoring divide unit with start/done interface.
// Present only when EXEC_MULDIV_EN is defined.
`ifdef EXEC_MULDIV_EN
module muldiv_iter
  import exec_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic                      i_is_div,
  input  logic                      i_signed,
  input  logic                      i_rem,
  input  logic [BUS_DATA_WIDTH-1:0] i_a,
  input  logic [BUS_DATA_WIDTH-1:0] i_b,
  output logic                      o_done_c,
  output logic [BUS_DATA_WIDTH-1:0] o_result_c
);

  logic                      r_busy;
  logic                      r_is_div;
  logic                      r_rem;
  logic                      r_neg_q;
  logic                      r_neg_r;
  logic [CNT_W-1:0]          r_cnt;
  // acc: product or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
  logic [BUS_DATA_WIDTH-1:0] r_acc;
  logic [BUS_DATA_WIDTH-1:0] r_x;
  logic [BUS_DATA_WIDTH-1:0] r_y;

  logic                      w_neg_a;
  logic                      w_neg_b;
  logic [BUS_DATA_WIDTH-1:0] w_mag_a;
  logic [BUS_DATA_WIDTH-1:0] w_mag_b;
  logic                      w_last;
  logic [BUS_DATA_WIDTH:0]   w_rsh;
  logic                      w_ge;
  logic [BUS_DATA_WIDTH-1:0] w_rsub;
  logic [BUS_DATA_WIDTH-1:0] w_q_fix;
  logic [BUS_DATA_WIDTH-1:0] w_r_fix;

  assign w_neg_a = i_signed & i_a[BUS_DATA_WIDTH-1];
  assign w_neg_b = i_signed & i_b[BUS_DATA_WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;
  assign w_last  = (r_cnt == CNT_W'(ITER_COUNT));

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign w_rsh  = {r_acc, r_x[BUS_DATA_WIDTH-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_y});
  assign w_rsub = BUS_DATA_WIDTH'(w_rsh - {1'b0, r_y});

  assign w_q_fix    = r_neg_q ? -r_x : r_x;
  assign w_r_fix    = r_neg_r ? -r_acc : r_acc;
  assign o_done_c   = r_busy && w_last;
  assign o_result_c = !r_is_div ? r_acc : (r_rem ? w_r_fix : w_q_fix);

  // Multiply performs its first step at start; divide first latches operand magnitudes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_rem    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_is_div <= i_is_div;
      r_rem    <= i_rem;
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
      if (i_is_div) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_x   <= w_mag_a;
        r_y   <= w_mag_b;
      end else begin
        r_cnt <= CNT_W'(1);
        r_acc <= i_b[0] ? i_a : '0;
        r_x   <= i_a << 1;
        r_y   <= i_b >> 1;
      end
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_is_div) begin
          r_acc <= w_ge ? w_rsub : w_rsh[BUS_DATA_WIDTH-1:0];
          r_x   <= {r_x[BUS_DATA_WIDTH-2:0], w_ge};
        end else begin
          r_acc <= r_acc + (r_y[0] ? r_x : '0);
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus optional iterative mul/div, registered writeback packet.
// EXEC_MULDIV_EN enables opcodes 16-20 and the ready/valid stall path.
module exec_stage
  import exec_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           alu_control,
  input  logic [BUS_DATA_WIDTH-1:0] dataA,
  input  logic [BUS_DATA_WIDTH-1:0] dataB,
  input  logic [REG_W-1:0]          addressC,
  output logic                      wb_valid,
  output logic                      wb_write_en,
  output logic [REG_W-1:0]          wb_addr,
  output logic [BUS_DATA_WIDTH-1:0] wb_data
);

  wb_pkt_t  r_wb;
  wb_pkt_t  w_wb_next;
  alu_res_t w_alu;
  logic     w_accept;

  assign w_alu       = alu_single(alu_control, dataA, dataB);
  assign wb_valid    = r_wb.valid;
  assign wb_write_en = r_wb.write_en;
  assign wb_addr     = r_wb.addr;
  assign wb_data     = r_wb.data;

`ifdef EXEC_MULDIV_EN
  state_e                    r_state;
  state_e                    w_state_next;
  logic                      r_in_ready;
  logic [REG_W-1:0]          r_addr;
  logic                      w_start;
  logic                      w_is_mul;
  logic                      w_is_div;
  alu_res_t                  w_short;
  logic                      w_md_done_c;
  logic [BUS_DATA_WIDTH-1:0] w_md_result_c;

  assign in_ready = r_in_ready;
  assign w_accept = in_valid && r_in_ready;
  assign w_is_mul = (alu_control == OP_MUL);
  assign w_is_div = (alu_control == OP_DIV) || (alu_control == OP_DIVU) ||
                    (alu_control == OP_REM) || (alu_control == OP_REMU);
  assign w_short  = div_shortcut(alu_control, dataA, dataB);

  muldiv_iter u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_is_div   (w_is_div),
    .i_signed   ((alu_control == OP_DIV) || (alu_control == OP_REM)),
    .i_rem      ((alu_control == OP_REM) || (alu_control == OP_REMU)),
    .i_a        (dataA),
    .i_b        (dataB),
    .o_done_c   (w_md_done_c),
    .o_result_c (w_md_result_c)
  );

  // Next-state and writeback packet selection.
  always_comb begin
    w_state_next = r_state;
    w_wb_next    = '0;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_start      = 1'b1;
            w_state_next = ST_MUL;
          end else if (w_is_div && !w_short.ok) begin
            w_start      = 1'b1;
            w_state_next = ST_DIV;
          end else if (w_is_div) begin
            w_wb_next = make_pkt(1'b1, addressC, w_short.data);
          end else begin
            w_wb_next = make_pkt(w_alu.ok, addressC, w_alu.data);
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_md_done_c) begin
          w_state_next = ST_DONE;
          w_wb_next    = make_pkt(1'b1, r_addr, w_md_result_c);
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_addr     <= REG_ZERO;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == ST_IDLE);
      if (w_start) begin
        r_addr <= addressC;
      end
    end
  end
`else
  assign in_ready = 1'b1;
  assign w_accept = in_valid;

  always_comb begin
    w_wb_next = '0;
    if (w_accept) begin
      w_wb_next = make_pkt(w_alu.ok, addressC, w_alu.data);
    end
  end
`endif

  // Writeback packet register; valid is a one-cycle pulse per completed op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb <= '0;
    end else begin
      r_wb <= w_wb_next;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage; expectations follow EXEC_MULDIV_EN.
module tb_exec_stage;
  import exec_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] NEG7 = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;

`ifdef EXEC_MULDIV_EN
  localparam logic [63:0] EXP_DIV     = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] EXP_REM     = ONES;
  localparam logic [63:0] EXP_DIVU0   = ONES;
  localparam logic [63:0] EXP_REMOVF  = 64'd0;
  localparam logic [63:0] EXP_DIVU    = 64'd14;
  localparam logic [63:0] EXP_REMU    = 64'd2;
  localparam logic        EXP_MD_WE   = 1'b1;
  localparam int          EXP_DIV_LAT = 65;
  localparam logic        EXP_BUSY_RD = 1'b0;
`else
  localparam logic [63:0] EXP_DIV     = 64'd0;
  localparam logic [63:0] EXP_REM     = 64'd0;
  localparam logic [63:0] EXP_DIVU0   = 64'd0;
  localparam logic [63:0] EXP_REMOVF  = 64'd0;
  localparam logic [63:0] EXP_DIVU    = 64'd0;
  localparam logic [63:0] EXP_REMU    = 64'd0;
  localparam logic        EXP_MD_WE   = 1'b0;
  localparam int          EXP_DIV_LAT = 0;
  localparam logic        EXP_BUSY_RD = 1'b1;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_control;
  logic [63:0] dataA;
  logic [63:0] dataB;
  logic [4:0]  addressC;
  logic        wb_valid;
  logic        wb_write_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;

  int checks = 0;
  int errors = 0;

  exec_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .dataA       (dataA),
    .dataB       (dataB),
    .addressC    (addressC),
    .wb_valid    (wb_valid),
    .wb_write_en (wb_write_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    in_valid    = 1'b1;
    alu_control = op;
    dataA       = a;
    dataB       = b;
    addressC    = rd;
  endtask

  // Issue one op, measure cycles from acceptance to wb_valid, check the packet.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp_data,
                        input logic exp_we, input int exp_lat);
    int k;
    drive(op, a, b, rd);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (wb_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_lat));
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_we"}, 64'(wb_write_en), 64'(exp_we));
    check({tag, "_addr"}, 64'(wb_addr), 64'(rd));
    k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int k;
    int pulses;
    int wb_at;
    logic [63:0] mul_data;
    logic [4:0]  mul_addr;

    reset = 1'b1; in_valid = 1'b0; alu_control = '0; dataA = '0; dataB = '0; addressC = '0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_we", 64'(wb_write_en), 64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    reset = 1'b0;
    tick();

    // Back-to-back single-cycle ops
    drive(OP_ADD, 64'd5, 64'd7, 5'd3);
    tick();
    check("add_valid", 64'(wb_valid), 64'd1);
    check("add_data", wb_data, 64'd12);
    check("add_addr", 64'(wb_addr), 64'd3);
    check("add_we", 64'(wb_write_en), 64'd1);
    drive(OP_SUB, 64'd0, 64'd1, 5'd4);
    tick();
    check("sub_valid", 64'(wb_valid), 64'd1);
    check("sub_data", wb_data, ONES);
    check("sub_addr", 64'(wb_addr), 64'd4);
    in_valid = 1'b0;
    tick();
    check("idle_valid", 64'(wb_valid), 64'd0);

    run_op("sra", OP_SRA, MIN, 64'd4, 5'd1, 64'hF800_0000_0000_0000, 1'b1, 0);
    run_op("addw", OP_ADDW, 64'h7FFF_FFFF, 64'd1, 5'd2, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);
    run_op("slt", OP_SLT, ONES, 64'd1, 5'd2, 64'd1, 1'b1, 0);
    run_op("sltu", OP_SLTU, ONES, 64'd1, 5'd2, 64'd0, 1'b1, 0);
    run_op("sll", OP_SLL, 64'd3, 64'h41, 5'd2, 64'd6, 1'b1, 0);
    run_op("srl", OP_SRL, MIN, 64'd63, 5'd2, 64'd1, 1'b1, 0);
    run_op("xor", OP_XOR, 64'hF0F0, 64'h0FF0, 5'd2, 64'hFF00, 1'b1, 0);
    run_op("x0", OP_ADD, 64'd2, 64'd3, 5'd0, 64'd5, 1'b0, 0);
    run_op("undef", 6'd63, 64'd123, 64'd456, 5'd8, 64'd0, 1'b0, 0);

    // MUL with in_valid held high; a different op waits behind it
    drive(OP_MUL, 64'd3, NEG2, 5'd5);
    tick();
`ifdef EXEC_MULDIV_EN
    drive(OP_ADD, 64'd1, 64'd1, 5'd6);
    k = 0; pulses = 0; wb_at = -1; mul_data = '0; mul_addr = '0;
    while (in_ready !== 1'b1 && k < 200) begin
      if (wb_valid === 1'b1) begin
        pulses++;
        wb_at    = k;
        mul_data = wb_data;
        mul_addr = wb_addr;
      end
      tick();
      k++;
    end
    check("mul_ready_low", 64'(k), 64'd65);
    check("mul_pulses", 64'(pulses), 64'd1);
    check("mul_lat", 64'(wb_at), 64'd64);
    check("mul_data", mul_data, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mul_addr", 64'(mul_addr), 64'd5);
`else
    check("mul_valid", 64'(wb_valid), 64'd1);
    check("mul_we", 64'(wb_write_en), 64'd0);
    check("mul_data", wb_data, 64'd0);
    check("mul_ready", 64'(in_ready), 64'd1);
    drive(OP_ADD, 64'd1, 64'd1, 5'd6);
`endif
    tick();
    in_valid = 1'b0;
    check("after_mul_valid", 64'(wb_valid), 64'd1);
    check("after_mul_data", wb_data, 64'd2);
    check("after_mul_addr", 64'(wb_addr), 64'd6);
    tick();

    run_op("div", OP_DIV, NEG7, 64'd2, 5'd7, EXP_DIV, EXP_MD_WE, EXP_DIV_LAT);
    run_op("rem", OP_REM, NEG7, 64'd2, 5'd7, EXP_REM, EXP_MD_WE, EXP_DIV_LAT);
    run_op("divu", OP_DIVU, 64'd100, 64'd7, 5'd7, EXP_DIVU, EXP_MD_WE, EXP_DIV_LAT);
    run_op("remu", OP_REMU, 64'd100, 64'd7, 5'd7, EXP_REMU, EXP_MD_WE, EXP_DIV_LAT);
    run_op("divu0", OP_DIVU, 64'd7, 64'd0, 5'd7, EXP_DIVU0, EXP_MD_WE, 0);
    run_op("removf", OP_REM, MIN, ONES, 5'd7, EXP_REMOVF, EXP_MD_WE, 0);

    // Reset during a divide abandons it
    drive(OP_DIV, 64'd100, 64'd3, 5'd10);
    tick();
    in_valid = 1'b0;
    pulses = 0;
    repeat (30) begin
      tick();
      if (wb_valid === 1'b1) pulses++;
    end
    check("mid_busy_ready", 64'(in_ready), 64'(EXP_BUSY_RD));
    reset = 1'b1;
    tick();
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(wb_valid), 64'd0);
    check("mid_rst_data", wb_data, 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 64'(in_ready), 64'd1);
    repeat (80) begin
      tick();
      if (wb_valid === 1'b1) pulses++;
    end
    check("mid_rst_pulses", 64'(pulses), 64'd0);
    run_op("post_rst_add", OP_ADD, 64'd10, 64'd20, 5'd9, 64'd30, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
